// File: rtl/key_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : key_window_sequencer
// Purpose  : Key-sequence unlock controller for the BA13=0/BA12=1 read window.
// Revision : 1.0
// ============================================================================
module key_window_sequencer #(
    parameter int unsigned KEY_LEN        = 6,
    parameter logic [31:0] KEY            = 32'h0000_A5C3,
    parameter logic [3:0]  RELOCK_NIB     = 4'hF,
    parameter int unsigned GAP_TIMEOUT    = 255,
    parameter int unsigned UNLOCK_CYCLES  = 65535,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_valid,
    input  logic        SSER,
    input  logic [13:4] BA,
    input  logic        BR_W,
    output logic        unlocked,
    output logic        lockout,
    output logic [2:0]  key_step,
    output logic        rsp_oe,
    output logic [1:0]  rsp_data
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEQ      = 2'd1,
        S_UNLOCKED = 2'd2,
        S_LOCKOUT  = 2'd3
    } state_t;

    localparam logic [7:0]  C_GAP_LOAD    = 8'(GAP_TIMEOUT);
    localparam logic [15:0] C_UNL_LOAD    = 16'(UNLOCK_CYCLES);
    localparam logic [11:0] C_LOCK_LOAD   = 12'(LOCKOUT_CYCLES);
    localparam logic [1:0]  C_MAX_FAILS   = 2'(MAX_FAILS);
    localparam logic [2:0]  C_LAST_STEP   = 3'(KEY_LEN - 1);
    localparam logic [3:0]  C_KEY0        = KEY[3:0];
    localparam bit          C_ONE_STEP    = (KEY_LEN == 1);
    localparam bit          C_UNL_EXPIRES = (UNLOCK_CYCLES != 0);

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [1:0]  fail_q, fail_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] unl_q, unl_d;
    logic [11:0] lock_q, lock_d;
    logic        unlocked_q, lockout_q;

    logic        w_wr;
    logic [3:0]  w_nib;
    logic [3:0]  w_exp_nib;
    logic        w_match;
    logic        w_in_key;
    logic [1:0]  w_fail_inc;
    logic        w_unused_ba;

    assign w_wr        = bus_valid & ~SSER & ~BA[13] & BA[12] & BR_W;
    assign w_nib       = BA[7:4];
    assign w_exp_nib   = KEY[{step_q, 2'b00} +: 4];
    assign w_match     = (w_nib == w_exp_nib);
    assign w_in_key    = (state_q == S_IDLE) || (state_q == S_SEQ);
    assign w_fail_inc  = (fail_q == C_MAX_FAILS) ? fail_q : fail_q + 2'd1;
    assign w_unused_ba = ^BA[11:8];

    assign unlocked = unlocked_q;
    assign lockout  = lockout_q;
    assign key_step = step_q;
    assign rsp_oe   = w_wr;
    assign rsp_data = {unlocked_q, w_wr & w_in_key & w_match};

    // Timers hold their value at 0; a state leaves on the cycle it finds its timer already at 0.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        fail_d  = fail_q;
        gap_d   = gap_q;
        unl_d   = unl_q;
        lock_d  = lock_q;
        case (state_q)
            S_IDLE: begin
                if (w_wr && w_match) begin
                    if (C_ONE_STEP) begin
                        state_d = S_UNLOCKED;
                        fail_d  = 2'd0;
                        unl_d   = C_UNL_LOAD;
                    end else begin
                        state_d = S_SEQ;
                        step_d  = 3'd1;
                        gap_d   = C_GAP_LOAD;
                    end
                end
            end
            S_SEQ: begin
                if (w_wr) begin
                    if (w_match) begin
                        if (step_q == C_LAST_STEP) begin
                            state_d = S_UNLOCKED;
                            step_d  = 3'd0;
                            fail_d  = 2'd0;
                            unl_d   = C_UNL_LOAD;
                        end else begin
                            step_d = step_q + 3'd1;
                            gap_d  = C_GAP_LOAD;
                        end
                    end else begin
                        fail_d = w_fail_inc;
                        if (w_fail_inc == C_MAX_FAILS) begin
                            state_d = S_LOCKOUT;
                            step_d  = 3'd0;
                            lock_d  = C_LOCK_LOAD;
                        end else if (w_nib == C_KEY0) begin
                            step_d = 3'd1;
                            gap_d  = C_GAP_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            step_d  = 3'd0;
                        end
                    end
                end else if (gap_q == 8'd0) begin
                    state_d = S_IDLE;
                    step_d  = 3'd0;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_UNLOCKED: begin
                if (w_wr && (w_nib == RELOCK_NIB)) begin
                    state_d = S_IDLE;
                end else if (C_UNL_EXPIRES) begin
                    if (unl_q == 16'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        unl_d = unl_q - 16'd1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (lock_q == 12'd0) begin
                    state_d = S_IDLE;
                    fail_d  = 2'd0;
                end else begin
                    lock_d = lock_q - 12'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= 3'd0;
            fail_q     <= 2'd0;
            gap_q      <= 8'd0;
            unl_q      <= 16'd0;
            lock_q     <= 12'd0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            fail_q     <= fail_d;
            gap_q      <= gap_d;
            unl_q      <= unl_d;
            lock_q     <= lock_d;
            unlocked_q <= (state_d == S_UNLOCKED);
            lockout_q  <= (state_d == S_LOCKOUT);
        end
    end

endmodule
`default_nettype wire
